// File: rtl/llc_lookup_stage_if.sv
// Bundle of the set-read packet from local memory and the lookup result sent to process.
// master = the environment around the stage, slave = the lookup stage itself.
interface llc_lookup_stage_if #(
  parameter int WAYS       = 16,
  parameter int WAY_BITS   = 4,
  parameter int TAG_BITS   = 16,
  parameter int STATE_BITS = 3,
  parameter int CTRL_BITS  = 7
);
  logic                       in_valid;
  logic                       in_ready;
  logic [TAG_BITS-1:0]        in_tag;
  logic [WAYS*TAG_BITS-1:0]   in_tags;
  logic [WAYS*STATE_BITS-1:0] in_states;
  logic [WAY_BITS-1:0]        in_evict_way;
  logic [CTRL_BITS-1:0]       in_ctrl;

  logic                       out_valid;
  logic                       out_ready;
  logic                       out_hit;
  logic [WAY_BITS-1:0]        out_way;
  logic                       out_evict;
  logic                       out_all_sd;
  logic [WAY_BITS-1:0]        out_evict_next;
  logic [CTRL_BITS-1:0]       out_ctrl;

  modport master (
    output in_valid, in_tag, in_tags, in_states, in_evict_way, in_ctrl, out_ready,
    input  in_ready, out_valid, out_hit, out_way, out_evict, out_all_sd, out_evict_next, out_ctrl
  );

  modport slave (
    input  in_valid, in_tag, in_tags, in_states, in_evict_way, in_ctrl, out_ready,
    output in_ready, out_valid, out_hit, out_way, out_evict, out_all_sd, out_evict_next, out_ctrl
  );
endinterface

// File: rtl/llc_lookup_stage.sv
// Two-stage LLC tag lookup: S1 registers per-way match/invalid/SD vectors, S2 picks the way
// (hit, fill, round-robin evict skipping SD ways, or all-SD stall) and keeps hit/miss counters.
module llc_lookup_stage #(
  parameter int WAYS       = 16,
  parameter int WAY_BITS   = 4,
  parameter int TAG_BITS   = 16,
  parameter int STATE_BITS = 3,
  parameter int CTRL_BITS  = 7,
  parameter logic [STATE_BITS-1:0] ST_INVALID = STATE_BITS'(0),
  parameter logic [STATE_BITS-1:0] ST_SD      = STATE_BITS'(5)
) (
  input  logic                clk,
  input  logic                rst,
  llc_lookup_stage_if.slave   bus,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
);

  logic [WAYS-1:0] match_vec;
  logic [WAYS-1:0] inv_vec;
  logic [WAYS-1:0] sd_vec;

  logic                 s1_valid_reg;
  logic [WAYS-1:0]      s1_match_reg;
  logic [WAYS-1:0]      s1_inv_reg;
  logic [WAYS-1:0]      s1_sd_reg;
  logic [WAY_BITS-1:0]  s1_evict_reg;
  logic [CTRL_BITS-1:0] s1_ctrl_reg;

  logic                 out_valid_reg;
  logic                 out_hit_reg;
  logic [WAY_BITS-1:0]  out_way_reg;
  logic                 out_evict_reg;
  logic                 out_all_sd_reg;
  logic [WAY_BITS-1:0]  out_evict_next_reg;
  logic [CTRL_BITS-1:0] out_ctrl_reg;

  logic                 out_hit_next;
  logic [WAY_BITS-1:0]  out_way_next;
  logic                 out_evict_next_flag;
  logic                 out_all_sd_next;
  logic [WAY_BITS-1:0]  out_evict_ptr_next;

  logic [15:0]          hit_cnt_reg;
  logic [15:0]          miss_cnt_reg;

  logic                 stall;
  logic                 in_ready;
  logic                 out_xfer;

  // SD vector rotated so that bit k is way (evict pointer + k) mod WAYS
  logic [WAYS-1:0]      sd_rot;
  logic [WAY_BITS-1:0]  rr_offset;
  logic [WAY_BITS-1:0]  rr_victim;

  function automatic logic [WAY_BITS-1:0] lowest_set(input logic [WAYS-1:0] vec);
    lowest_set = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lowest_set = WAY_BITS'(i);
      end
    end
  endfunction

  assign stall        = out_valid_reg && !bus.out_ready;
  assign in_ready     = !s1_valid_reg || !stall;
  assign out_xfer     = out_valid_reg && bus.out_ready;
  assign bus.in_ready = in_ready;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [TAG_BITS-1:0]   way_tag;
    logic [STATE_BITS-1:0] way_state;

    assign way_tag       = bus.in_tags[gi*TAG_BITS +: TAG_BITS];
    assign way_state     = bus.in_states[gi*STATE_BITS +: STATE_BITS];
    assign inv_vec[gi]   = (way_state == ST_INVALID);
    assign sd_vec[gi]    = (way_state == ST_SD);
    assign match_vec[gi] = (way_tag == bus.in_tag) && (way_state != ST_INVALID);
  end

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_rot
    assign sd_rot[gi] = s1_sd_reg[s1_evict_reg + WAY_BITS'(gi)];
  end

  // S1: only advances when the slot is empty or S2 is draining this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_match_reg <= '0;
      s1_inv_reg   <= '0;
      s1_sd_reg    <= '0;
      s1_evict_reg <= '0;
      s1_ctrl_reg  <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_match_reg <= match_vec;
        s1_inv_reg   <= inv_vec;
        s1_sd_reg    <= sd_vec;
        s1_evict_reg <= bus.in_evict_way;
        s1_ctrl_reg  <= bus.in_ctrl;
      end
    end
  end

  always_comb begin
    rr_offset           = lowest_set(~sd_rot);
    rr_victim           = s1_evict_reg + rr_offset;
    out_hit_next        = 1'b0;
    out_way_next        = s1_evict_reg;
    out_evict_next_flag = 1'b0;
    out_all_sd_next     = 1'b0;
    out_evict_ptr_next  = s1_evict_reg;
    if (|s1_match_reg) begin
      out_hit_next = 1'b1;
      out_way_next = lowest_set(s1_match_reg);
    end else if (|s1_inv_reg) begin
      out_way_next = lowest_set(s1_inv_reg);
    end else if (!(&s1_sd_reg)) begin
      out_way_next        = rr_victim;
      out_evict_next_flag = 1'b1;
      out_evict_ptr_next  = rr_victim + WAY_BITS'(1);
    end else begin
      out_all_sd_next = 1'b1;
    end
  end

  // S2: outputs freeze while the process stage is not accepting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg      <= 1'b0;
      out_hit_reg        <= 1'b0;
      out_way_reg        <= '0;
      out_evict_reg      <= 1'b0;
      out_all_sd_reg     <= 1'b0;
      out_evict_next_reg <= '0;
      out_ctrl_reg       <= '0;
    end else if (!stall) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_hit_reg        <= out_hit_next;
        out_way_reg        <= out_way_next;
        out_evict_reg      <= out_evict_next_flag;
        out_all_sd_reg     <= out_all_sd_next;
        out_evict_next_reg <= out_evict_ptr_next;
        out_ctrl_reg       <= s1_ctrl_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (out_xfer) begin
      if (out_hit_reg) begin
        if (hit_cnt_reg != 16'hFFFF) begin
          hit_cnt_reg <= hit_cnt_reg + 16'd1;
        end
      end else if (miss_cnt_reg != 16'hFFFF) begin
        miss_cnt_reg <= miss_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.out_valid      = out_valid_reg;
  assign bus.out_hit        = out_hit_reg;
  assign bus.out_way        = out_way_reg;
  assign bus.out_evict      = out_evict_reg;
  assign bus.out_all_sd     = out_all_sd_reg;
  assign bus.out_evict_next = out_evict_next_reg;
  assign bus.out_ctrl       = out_ctrl_reg;
  assign hit_cnt            = hit_cnt_reg;
  assign miss_cnt           = miss_cnt_reg;

endmodule

// File: tb/tb_llc_lookup_stage.sv
// Directed bench for llc_lookup_stage: way-selection cases, backpressure ordering,
// counter saturation and asynchronous reset with packets in flight.
module tb_llc_lookup_stage;
  localparam int WAYS       = 16;
  localparam int WAY_BITS   = 4;
  localparam int TAG_BITS   = 16;
  localparam int STATE_BITS = 3;
  localparam int CTRL_BITS  = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  logic [TAG_BITS-1:0]   way_tags   [WAYS];
  logic [STATE_BITS-1:0] way_states [WAYS];
  logic [CTRL_BITS-1:0]  got_ctrl   [4];
  logic [WAY_BITS-1:0]   got_way    [4];
  int                    got_n;

  llc_lookup_stage_if #(
    .WAYS(WAYS), .WAY_BITS(WAY_BITS), .TAG_BITS(TAG_BITS),
    .STATE_BITS(STATE_BITS), .CTRL_BITS(CTRL_BITS)
  ) bus ();

  llc_lookup_stage #(
    .WAYS(WAYS), .WAY_BITS(WAY_BITS), .TAG_BITS(TAG_BITS),
    .STATE_BITS(STATE_BITS), .CTRL_BITS(CTRL_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic fill(input logic [TAG_BITS-1:0] t, input logic [STATE_BITS-1:0] s);
    for (int i = 0; i < WAYS; i++) begin
      way_tags[i]   = t;
      way_states[i] = s;
    end
  endtask

  task automatic apply_pkt(input logic [TAG_BITS-1:0] t, input logic [WAY_BITS-1:0] ev,
                           input logic [CTRL_BITS-1:0] c);
    for (int i = 0; i < WAYS; i++) begin
      bus.in_tags[i*TAG_BITS +: TAG_BITS]       = way_tags[i];
      bus.in_states[i*STATE_BITS +: STATE_BITS] = way_states[i];
    end
    bus.in_tag       = t;
    bus.in_evict_way = ev;
    bus.in_ctrl      = c;
  endtask

  // One packet through an idle pipeline with out_ready held high.
  task automatic run_one(input string name, input logic [WAY_BITS-1:0] ev, input logic [CTRL_BITS-1:0] c,
                         input logic e_hit, input logic [WAY_BITS-1:0] e_way, input logic e_evict,
                         input logic e_all_sd, input logic [WAY_BITS-1:0] e_next);
    int lat;
    apply_pkt(16'h1234, ev, c);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({name, "_latency"}, lat, 2);
    check_eq({name, "_hit"}, bus.out_hit, e_hit);
    check_eq({name, "_way"}, bus.out_way, e_way);
    check_eq({name, "_evict"}, bus.out_evict, e_evict);
    check_eq({name, "_all_sd"}, bus.out_all_sd, e_all_sd);
    check_eq({name, "_evict_next"}, bus.out_evict_next, e_next);
    check_eq({name, "_ctrl"}, bus.out_ctrl, c);
    $display("lookup %s: hit=%0d way=%0d evict=%0d all_sd=%0d evict_next=%0d ctrl=0x%0h",
             name, bus.out_hit, bus.out_way, bus.out_evict, bus.out_all_sd, bus.out_evict_next, bus.out_ctrl);
    if (e_hit) exp_hit++;
    else exp_miss++;
    @(posedge clk); #1;
    check_eq({name, "_hit_cnt"}, hit_cnt, exp_hit);
    check_eq({name, "_miss_cnt"}, miss_cnt, exp_miss);
  endtask

  task automatic backpressure_test();
    logic [CTRL_BITS-1:0] bp_ctrl [4];
    bp_ctrl = '{7'h11, 7'h22, 7'h33, 7'h44};
    bus.out_ready = 1'b0;
    got_n = 0;
    fork
      begin
        for (int p = 0; p < 4; p++) begin
          int   w;
          logic acc;
          fill(16'hAAAA, 3'd1);
          way_tags[p+1] = 16'h1234;
          apply_pkt(16'h1234, 4'd0, bp_ctrl[p]);
          bus.in_valid = 1'b1;
          w = 0;
          acc = 1'b0;
          do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            w++;
          end while (!acc && w < 20);
          check_eq("bp_accept", acc, 1'b1);
        end
        bus.in_valid = 1'b0;
      end
      begin
        int w;
        @(negedge clk);
        w = 0;
        while (!bus.out_valid && w < 10) begin
          @(negedge clk);
          w++;
        end
        for (int c = 0; c < 3; c++) begin
          check_eq("bp_hold_valid", bus.out_valid, 1'b1);
          check_eq("bp_hold_in_ready", bus.in_ready, 1'b0);
          check_eq("bp_hold_ctrl", bus.out_ctrl, bp_ctrl[0]);
          check_eq("bp_hold_way", bus.out_way, 4'd1);
          if (c < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
      begin
        for (int cyc = 0; cyc < 60 && got_n < 4; cyc++) begin
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) begin
            got_ctrl[got_n] = bus.out_ctrl;
            got_way[got_n]  = bus.out_way;
            $display("deliver %0d: way=%0d ctrl=0x%0h", got_n, bus.out_way, bus.out_ctrl);
            got_n++;
          end
        end
      end
    join
    @(posedge clk); #1;
    check_eq("bp_count", got_n, 4);
    check_eq("bp_drained", bus.out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_order_ctrl", got_ctrl[i], bp_ctrl[i]);
      check_eq("bp_order_way", got_way[i], WAY_BITS'(i + 1));
    end
    exp_hit += 4;
    check_eq("bp_hit_cnt", hit_cnt, exp_hit);
  endtask

  initial begin
    int seen;
    bus.in_valid     = 1'b0;
    bus.in_tag       = '0;
    bus.in_tags      = '0;
    bus.in_states    = '0;
    bus.in_evict_way = '0;
    bus.in_ctrl      = '0;
    bus.out_ready    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_out_way", bus.out_way, 4'd0);
    check_eq("rst_evict_next", bus.out_evict_next, 4'd0);
    check_eq("rst_ctrl", bus.out_ctrl, 7'd0);
    check_eq("rst_hit_cnt", hit_cnt, 16'd0);
    check_eq("rst_miss_cnt", miss_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_in_ready", bus.in_ready, 1'b1);

    // hit in way 5; invalid ways carry the same tag and must not match
    fill(16'h1234, 3'd0);
    way_states[5] = 3'd3;
    run_one("hit", 4'd9, 7'h55, 1'b1, 4'd5, 1'b0, 1'b0, 4'd9);

    fill(16'hAAAA, 3'd3);
    way_states[2] = 3'd0;
    way_states[9] = 3'd0;
    way_tags[2]   = 16'h1234;
    run_one("inv_fill", 4'd7, 7'h01, 1'b0, 4'd2, 1'b0, 1'b0, 4'd7);

    fill(16'hAAAA, 3'd3);
    way_states[14] = 3'd5;
    way_states[15] = 3'd5;
    run_one("wrap_evict", 4'd14, 7'h02, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1);

    fill(16'hAAAA, 3'd2);
    way_states[4] = 3'd5;
    run_one("skip_sd", 4'd4, 7'h04, 1'b0, 4'd5, 1'b1, 1'b0, 4'd6);

    fill(16'hAAAA, 3'd1);
    run_one("evict_15", 4'd15, 7'h08, 1'b0, 4'd15, 1'b1, 1'b0, 4'd0);

    fill(16'hAAAA, 3'd5);
    run_one("all_sd", 4'd3, 7'h10, 1'b0, 4'd3, 1'b0, 1'b1, 4'd3);

    fill(16'hAAAA, 3'd5);
    way_tags[7] = 16'h1234;
    run_one("sd_hit", 4'd3, 7'h20, 1'b1, 4'd7, 1'b0, 1'b0, 4'd3);

    fill(16'hAAAA, 3'd1);
    way_tags[3]  = 16'h1234;
    way_tags[11] = 16'h1234;
    run_one("multi_hit", 4'd6, 7'h7F, 1'b1, 4'd3, 1'b0, 1'b0, 4'd6);

    backpressure_test();

    // saturation: one hit delivered per cycle for 65536 cycles
    fill(16'hAAAA, 3'd0);
    way_tags[0]   = 16'h1234;
    way_states[0] = 3'd1;
    apply_pkt(16'h1234, 4'd0, 7'h00);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("sat_hit_cnt", hit_cnt, 16'hFFFF);
    check_eq("sat_miss_cnt", miss_cnt, exp_miss);
    $display("saturate: hit_cnt=0x%0h miss_cnt=0x%0h", hit_cnt, miss_cnt);

    // reset with two packets in flight, stage output blocked
    fill(16'hAAAA, 3'd1);
    way_tags[6] = 16'h1234;
    apply_pkt(16'h1234, 4'd5, 7'h33);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("inflight_valid", bus.out_valid, 1'b1);
    check_eq("inflight_way", bus.out_way, 4'd6);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_out_valid", bus.out_valid, 1'b0);
    check_eq("arst_out_way", bus.out_way, 4'd0);
    check_eq("arst_evict_next", bus.out_evict_next, 4'd0);
    check_eq("arst_ctrl", bus.out_ctrl, 7'd0);
    check_eq("arst_out_hit", bus.out_hit, 1'b0);
    check_eq("arst_hit_cnt", hit_cnt, 16'd0);
    check_eq("arst_miss_cnt", miss_cnt, 16'd0);
    $display("async reset: out_valid=%0d hit_cnt=%0d miss_cnt=%0d", bus.out_valid, hit_cnt, miss_cnt);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check_eq("no_replay", seen, 0);
    check_eq("post_rst_hit_cnt", hit_cnt, 16'd0);
    check_eq("post_rst_in_ready", bus.in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
